// File: rtl/vga_spot_tracker_if.sv
// Frame-buffer read port, VGA pins and spot report of vga_spot_tracker.
// The master side is the tracker; the slave side is the RAM/pins/consumer.
interface vga_spot_tracker_if #(
  parameter int PIX_W  = 4,
  parameter int ADDR_W = 19
) ();

  logic [ADDR_W-1:0]  frame_addr;
  logic [3*PIX_W-1:0] frame_pixel;
  logic [PIX_W-1:0]   vga_red;
  logic [PIX_W-1:0]   vga_green;
  logic [PIX_W-1:0]   vga_blue;
  logic               vga_hSync;
  logic               vga_vSync;
  logic               spot_valid;
  logic [9:0]         spot_x;
  logic [9:0]         spot_y;
  logic               frame_done;

  modport master (
    output frame_addr,
    input  frame_pixel,
    output vga_red,
    output vga_green,
    output vga_blue,
    output vga_hSync,
    output vga_vSync,
    output spot_valid,
    output spot_x,
    output spot_y,
    output frame_done
  );

  modport slave (
    input  frame_addr,
    output frame_pixel,
    input  vga_red,
    input  vga_green,
    input  vga_blue,
    input  vga_hSync,
    input  vga_vSync,
    input  spot_valid,
    input  spot_x,
    input  spot_y,
    input  frame_done
  );

endinterface

// File: rtl/vga_spot_tracker.sv
// VGA scan-out with brightest-red spot tracking and a square marker
// drawn on the following frame at the committed spot.
module vga_spot_tracker #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_W     = 4,
  parameter int ADDR_W    = 19,
  parameter int MARK_HALF = 10,
  parameter int EDGE_SKIP = 4
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic [PIX_W-1:0] threshold,
  vga_spot_tracker_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int MW = (HW > VW) ? HW : VW;
  localparam int CW = ((MW > 10) ? MW : 10) + 2;

  typedef logic [HW-1:0] h_t;
  typedef logic [VW-1:0] v_t;
  typedef logic [9:0]    c_t;

  localparam h_t H_LAST = h_t'(H_TOTAL - 1);
  localparam h_t H_ACT  = h_t'(H_ACTIVE);
  localparam h_t HS_ON  = h_t'(H_ACTIVE + H_FP);
  localparam h_t HS_OFF = h_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam h_t H_SKIP = h_t'(EDGE_SKIP);
  localparam v_t V_LAST = v_t'(V_TOTAL - 1);
  localparam v_t V_ACT  = v_t'(V_ACTIVE);
  localparam v_t VS_ON  = v_t'(V_ACTIVE + V_FP);
  localparam v_t VS_OFF = v_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic signed [CW-1:0] MH = CW'(MARK_HALF);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    h_t   h;
    v_t   v;
  } pix_t;

  localparam pix_t PIX_RST = '{
    act: 1'b0,
    hs:  ~HSYNC_POL,
    vs:  ~VSYNC_POL,
    h:   '0,
    v:   '0
  };

  h_t                h_q;
  h_t                h_d;
  v_t                v_q;
  v_t                v_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              h_wrap;
  logic              v_blank_d;
  logic              h_blank_d;
  logic              origin_d;

  pix_t s0;
  pix_t s1;

  logic [PIX_W-1:0] red;
  logic [PIX_W-1:0] grn;
  logic [PIX_W-1:0] blu;
  logic             cand;
  logic             better;
  logic             commit;
  logic             mark;

  logic signed [CW-1:0] dx;
  logic signed [CW-1:0] dy;

  logic [PIX_W-1:0] best_red_q;
  c_t               best_x_q;
  c_t               best_y_q;
  logic             found_q;
  c_t               spot_x_q;
  c_t               spot_y_q;
  logic             spot_valid_q;
  logic             done_q;

  logic [3*PIX_W-1:0] rgb_q;
  logic               hs_q;
  logic               vs_q;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + h_t'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + v_t'(1);
    end
  end

  // Address runs with the scan: hold through h-blank, zero in v-blank.
  always_comb begin
    v_blank_d = (v_d >= V_ACT);
    h_blank_d = !v_blank_d && (h_d >= H_ACT);
    origin_d  = (h_d == '0) && (v_d == '0);
    addr_d    = addr_q;
    unique case (1'b1)
      v_blank_d, origin_d: addr_d = '0;
      h_blank_d:           addr_d = addr_q;
      default:             addr_d = addr_q + ADDR_W'(1);
    endcase
  end

  always_comb begin
    s0     = PIX_RST;
    s0.act = (h_q < H_ACT) && (v_q < V_ACT);
    s0.h   = h_q;
    s0.v   = v_q;
    s0.hs  = (h_q >= HS_ON && h_q < HS_OFF) ?
             HSYNC_POL : ~HSYNC_POL;
    s0.vs  = (v_q >= VS_ON && v_q < VS_OFF) ?
             VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      s1     <= PIX_RST;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      s1     <= s0;
    end
  end

  assign {red, grn, blu} = bus.frame_pixel;

  always_comb begin
    cand   = s1.act && (red > threshold) && (s1.h >= H_SKIP);
    better = cand && (!found_q || red > best_red_q);
    commit = (s1.v == V_ACT) && (s1.h == '0);
  end

  // Widened signed distance so the marker clips instead of wrapping.
  always_comb begin
    dx   = $signed(CW'(s1.h)) - $signed(CW'(spot_x_q));
    dy   = $signed(CW'(s1.v)) - $signed(CW'(spot_y_q));
    mark = spot_valid_q &&
           (dx > -MH) && (dx < MH) &&
           (dy > -MH) && (dy < MH);
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      best_red_q   <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      found_q      <= 1'b0;
      spot_x_q     <= '0;
      spot_y_q     <= '0;
      spot_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        if (found_q) begin
          spot_x_q <= best_x_q;
          spot_y_q <= best_y_q;
        end
        spot_valid_q <= found_q;
        best_red_q   <= '0;
        best_x_q     <= '0;
        best_y_q     <= '0;
        found_q      <= 1'b0;
      end else if (better) begin
        best_red_q <= red;
        best_x_q   <= c_t'(s1.h);
        best_y_q   <= c_t'(s1.v);
        found_q    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      rgb_q <= '0;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
    end else begin
      rgb_q <= (s1.act && !mark) ? bus.frame_pixel : '0;
      hs_q  <= s1.hs;
      vs_q  <= s1.vs;
    end
  end

  assign bus.frame_addr = addr_q;
  assign {bus.vga_red, bus.vga_green, bus.vga_blue} = rgb_q;
  assign bus.vga_hSync  = hs_q;
  assign bus.vga_vSync  = vs_q;
  assign bus.spot_valid = spot_valid_q;
  assign bus.spot_x     = spot_x_q;
  assign bus.spot_y     = spot_y_q;
  assign bus.frame_done = done_q;

endmodule

// File: doc/vga_spot_tracker.md
Name: vga_spot_tracker

Overview:
Parametrised successor to the fixed 640x480 VGA scan-out block. It generates VGA timing with configurable geometry and sync polarity and fetches pixels from a 1-cycle-latency frame buffer. It tracks the brightest red spot per frame, committing coordinates only at frame end so they never tear, and overlays a square marker at the committed location on the next frame. It sits between the camera frame buffer and the VGA pins; spot coordinates feed LEDs and downstream control.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync
VSYNC_POL, 0, active level of vsync
PIX_W, 4, bits per colour channel
ADDR_W, 19, frame buffer address width
MARK_HALF, 10, marker half-size; pixels with |dx|<MARK_HALF and |dy|<MARK_HALF are marked
EDGE_SKIP, 4, columns x<EDGE_SKIP excluded from tracking

Ports:
clk25  in  1  pixel clock
reset  in  1  synchronous, active-high reset
threshold  in  PIX_W  red level a pixel must strictly exceed to be a candidate
frame_addr  out  ADDR_W  frame buffer read address
frame_pixel  in  3*PIX_W  {R,G,B} read data, valid 1 cycle after frame_addr
vga_red  out  PIX_W  red
vga_green  out  PIX_W  green
vga_blue  out  PIX_W  blue
vga_hSync  out  1  horizontal sync
vga_vSync  out  1  vertical sync
spot_valid  out  1  committed spot exists
spot_x  out  10  committed spot column
spot_y  out  10  committed spot line
frame_done  out  1  1-cycle pulse at commit

Behaviour:
- Counters: h counts 0..H_TOTAL-1 (H_TOTAL = sum of H_*); at wrap v increments 0..V_TOTAL-1 and wraps to 0.
- frame_addr: v*H_ACTIVE+h while h<H_ACTIVE and v<V_ACTIVE, as a running register (increment in active, hold in h-blank, 0 from v>=V_ACTIVE). Stage 0.
- Stage 1: frame_pixel sampled with registered h, v, active flag.
- Stage 2 (outputs registered): RGB = frame_pixel if active, else 0. Syncs are delayed by the same 2 cycles. Pixel (h,v) is therefore on the pins 2 cycles after the counter is at (h,v).
- hsync is active for H_SYNC clocks starting at h = H_ACTIVE+H_FP; vsync is active for V_SYNC lines starting at v = V_ACTIVE+V_FP (both at stage 0, then delayed). Inactive level = ~POL.
- Tracker (stage 1): a candidate is active, red>threshold, and x>=EDGE_SKIP. Keep best_red/best_x/best_y/found. Replace on strictly greater red, so ties keep the first in raster order. found is set on the first candidate.
- Commit: when stage-1 enters the first non-active line (v==V_ACTIVE, h==0):
  - spot_x/spot_y <= best_x/best_y when found; otherwise values hold.
  - spot_valid <= found.
  - frame_done pulses 1 cycle.
  - best_* and found clear in the same cycle.
- Overlay (stage 2): if spot_valid and the pixel lies inside the marker, RGB forced to 0. The comparison is signed/widened (no unsigned underflow near 0; marker clips at edges). Blanking is unaffected.
- Spot registers change only at commit, so the overlay is stable for a whole frame.
- Reset (any time, incl. mid-frame), next edge:
  - h, v, frame_addr = 0; pipeline flags inactive.
  - RGB = 0; syncs at inactive level.
  - spot_valid = 0, spot_x/y = 0, frame_done = 0; tracker cleared.
  - Scan restarts at (0,0) the cycle after reset deasserts.

Test Plan:
- Default params, reset then 2 frames -> hsync low exactly 96 of every 800 clocks; vsync low exactly 2 of every 525 lines (1600 clocks), both lagging counter sync windows by 2 cycles.
- Monitor frame_addr -> 0,1,...,639 held through h-blank, 640... ending 307199, then 0 throughout v-blank; repeats each frame.
- frame_pixel=12'hF80 model with 1-cycle RAM, active region -> RGB=F,8,0 appears exactly 2 cycles after counter (0,0); 0 in blank.
- Threshold 14; only pixel (100,50) red=15 -> frame_done pulse, spot_x=100, spot_y=50, spot_valid=1; next frame RGB=0 for x 91..109, y 41..59 (19x19), normal elsewhere.
- Red=15 at (2,10) and (300,200) and (400,200) -> x=2 ignored, tie keeps (300,200); next frame with no candidates -> spot_valid=0, coordinates hold, no marker.
- Spot at (3... use (5,5)) -> marker clipped to x 0..14, y 0..14 without wrap artefacts; assert reset at v=200 -> next cycle frame_addr=0, RGB=0, syncs high, spot_valid=0.
